// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding and one-hot helper for decoder_onehot_seq
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Widest select supported by the helper; callers truncate to their OUT_W.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        return MAX_OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/decoder_onehot_seq_scan_divider.sv
// rtl/decoder_onehot_seq_scan_divider.sv - SCAN_DIV cycle counter with step pulse and sync clear
module scan_divider #(
    parameter int SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_cnt_en,
    output logic o_step
);

    localparam int CNT_W = $clog2(SCAN_DIV + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign o_step   = i_cnt_en & w_at_end;

    // Count while enabled, restarting after each step; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en) begin
            r_cnt <= w_at_end ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/decoder_onehot_seq.sv
// rtl/decoder_onehot_seq.sv - registered one-hot decoder with DIRECT/SCAN modes; DECODER_ACTIVE_LOW_EN inverts y
module decoder_onehot_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   y,
    output logic                  y_valid,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  wrap
);

    localparam int OUT_W = 2 ** SEL_W;

    state_t            r_state;
    state_t            w_next_state;
    logic [OUT_W-1:0]  r_y;
    logic              r_y_valid;
    logic [SEL_W-1:0]  r_cur_idx;
    logic              r_wrap;

    logic              w_xfer;
    logic              w_step;
    logic              w_scan_clr;
    logic              w_scan_cnt_en;
    logic              w_last;
    logic [SEL_W-1:0]  w_idx_inc;
    logic [OUT_W-1:0]  w_y_sel;
    logic [OUT_W-1:0]  w_y_inc;

    assign in_ready      = en & ~mode;
    assign w_xfer        = in_valid & in_ready;
    assign w_last        = (r_cur_idx == SEL_W'(OUT_W - 1));
    assign w_idx_inc     = r_cur_idx + SEL_W'(1);
    assign w_y_sel       = OUT_W'(onehot(MAX_SEL_W'(sel)));
    assign w_y_inc       = OUT_W'(onehot(MAX_SEL_W'(w_idx_inc)));
    assign w_scan_cnt_en = (r_state == SCAN) && (w_next_state == SCAN);
    assign w_scan_clr    = !w_scan_cnt_en;

    scan_divider #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_scan_clr),
        .i_cnt_en (w_scan_cnt_en),
        .o_step   (w_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: en dominates, otherwise mode picks DIRECT or SCAN from any state.
    always_comb begin
        w_next_state = IDLE;
        if (en) begin
            w_next_state = mode ? SCAN : DIRECT;
        end
    end

    // Output registers, updated according to the state being entered at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_cur_idx <= '0;
            r_wrap    <= 1'b0;
        end else begin
            case (w_next_state)
                DIRECT: begin
                    r_wrap <= 1'b0;
                    if (w_xfer) begin
                        r_y       <= w_y_sel;
                        r_cur_idx <= sel;
                        r_y_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (r_state != SCAN) begin
                        r_y       <= OUT_W'(1);
                        r_cur_idx <= '0;
                        r_y_valid <= 1'b1;
                        r_wrap    <= 1'b0;
                    end else if (w_step) begin
                        r_y       <= w_y_inc;
                        r_cur_idx <= w_idx_inc;
                        r_wrap    <= w_last;
                    end else begin
                        r_wrap    <= 1'b0;
                    end
                end
                default: begin
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                    r_wrap    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~r_y;
`else
    assign y = r_y;
`endif
    assign y_valid = r_y_valid;
    assign cur_idx = r_cur_idx;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// tb/tb_decoder_onehot_seq.sv - self-checking bench for decoder_onehot_seq (default and DECODER_ACTIVE_LOW_EN builds)
module tb_decoder_onehot_seq;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam int SEL_W    = 4;
    localparam int SCAN_DIV = 1;
`else
    localparam int SEL_W    = 3;
    localparam int SCAN_DIV = 4;
`endif
    localparam int OUT_W = 2 ** SEL_W;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] y;
    logic             y_valid;
    logic [SEL_W-1:0] cur_idx;
    logic             wrap;

    int n_checks = 0;
    int n_err    = 0;
    int m_idx;
    int m_div;
    int m_wrap;
    int n_wraps;

    typedef struct {
        logic             vld;
        logic [SEL_W-1:0] sel;
        logic [OUT_W-1:0] y;
        logic             y_valid;
        logic [SEL_W-1:0] idx;
    } vec_t;

    vec_t vecs[6];

    decoder_onehot_seq #(
        .SEL_W    (SEL_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .y        (y),
        .y_valid  (y_valid),
        .cur_idx  (cur_idx),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] ey(input logic [OUT_W-1:0] a);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~a;
`else
        return a;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scan_entry_check(input string name);
        m_idx  = 0;
        m_div  = 0;
        m_wrap = 0;
        chk({name, "_y"}, 32'(y), 32'(ey(OUT_W'(1))));
        chk({name, "_idx"}, 32'(cur_idx), 32'd0);
        chk({name, "_valid"}, 32'(y_valid), 32'd1);
        chk({name, "_wrap"}, 32'(wrap), 32'd0);
    endtask

    task automatic scan_cycle();
        step();
        if (m_div == SCAN_DIV - 1) begin
            m_div  = 0;
            m_idx  = (m_idx + 1) % OUT_W;
            m_wrap = (m_idx == 0) ? 1 : 0;
        end else begin
            m_div  = m_div + 1;
            m_wrap = 0;
        end
        if (m_wrap != 0) n_wraps++;
        chk("scan_y", 32'(y), 32'(ey(OUT_W'(1) << m_idx)));
        chk("scan_idx", 32'(cur_idx), 32'(m_idx));
        chk("scan_wrap", 32'(wrap), 32'(m_wrap));
        chk("scan_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic scan_until(input int target);
        int guard;
        guard = 0;
        while (m_idx != target && guard < 1000) begin
            scan_cycle();
            guard++;
        end
        chk("scan_reach_idx", 32'(m_idx), 32'(target));
    endtask

    initial begin
        vecs[0] = '{1'b1, SEL_W'(5), OUT_W'(8'h20), 1'b1, SEL_W'(5)};
        vecs[1] = '{1'b0, SEL_W'(2), OUT_W'(8'h20), 1'b1, SEL_W'(5)};
        vecs[2] = '{1'b1, SEL_W'(0), OUT_W'(8'h01), 1'b1, SEL_W'(0)};
        vecs[3] = '{1'b1, SEL_W'(7), OUT_W'(8'h80), 1'b1, SEL_W'(7)};
        vecs[4] = '{1'b1, SEL_W'(2), OUT_W'(8'h04), 1'b1, SEL_W'(2)};
        vecs[5] = '{1'b0, SEL_W'(7), OUT_W'(8'h04), 1'b1, SEL_W'(2)};

        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        sel      = '0;
        n_wraps  = 0;
        step();
        chk("rst_y", 32'(y), 32'(ey('0)));
        chk("rst_valid", 32'(y_valid), 32'd0);
        chk("rst_idx", 32'(cur_idx), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        step();

        // Enter DIRECT without a transfer: nothing valid yet.
        en = 1'b1;
        #1 chk("direct_ready", 32'(in_ready), 32'd1);
        step();
        chk("direct_entry_valid", 32'(y_valid), 32'd0);
        chk("direct_entry_y", 32'(y), 32'(ey('0)));

        // Table: single transfer, idle cycle, back-to-back transfers.
        for (int i = 0; i < 6; i++) begin
            in_valid = vecs[i].vld;
            sel      = vecs[i].sel;
            step();
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(ey(vecs[i].y)));
            chk($sformatf("vec%0d_valid", i), 32'(y_valid), 32'(vecs[i].y_valid));
            chk($sformatf("vec%0d_idx", i), 32'(cur_idx), 32'(vecs[i].idx));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'd0);
        end
        in_valid = 1'b0;

        // Hold with no transfer.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_y", 32'(y), 32'(ey(OUT_W'(8'h04))));
        end

        // Switch to SCAN in the same cycle as in_valid: no transfer, scan entry load.
        mode     = 1'b1;
        in_valid = 1'b1;
        sel      = SEL_W'(3);
        #1 chk("switch_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        scan_entry_check("scan_entry");

        // Two full index periods: exactly two wrap pulses.
        for (int i = 0; i < 2 * OUT_W * SCAN_DIV; i++) scan_cycle();
        chk("wrap_count", 32'(n_wraps), 32'd2);

        // Drop en mid-scan at index 3.
        scan_until(3);
        en = 1'b0;
        step();
        chk("drop_en_y", 32'(y), 32'(ey('0)));
        chk("drop_en_valid", 32'(y_valid), 32'd0);
        chk("drop_en_idx", 32'(cur_idx), 32'd3);
        en = 1'b1;
        step();
        scan_entry_check("rescan");

        // SCAN -> DIRECT keeps the last scan value valid.
        scan_until(2);
        mode = 1'b0;
        step();
        chk("to_direct_y", 32'(y), 32'(ey(OUT_W'(4))));
        chk("to_direct_valid", 32'(y_valid), 32'd1);
        chk("to_direct_idx", 32'(cur_idx), 32'd2);
        mode = 1'b1;
        step();
        scan_entry_check("rescan2");

        // Asynchronous reset between edges at index 6.
        scan_until(6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y", 32'(y), 32'(ey('0)));
        chk("async_rst_valid", 32'(y_valid), 32'd0);
        chk("async_rst_idx", 32'(cur_idx), 32'd0);
        en   = 1'b0;
        mode = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", 32'(y_valid), 32'd0);
            chk("post_rst_y", 32'(y), 32'(ey('0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
